// File: rtl/sprite_drawer.sv
// sprite_drawer: answers the movement FSM's drawBG/drawChar handshake by
// painting a SPRITE_W x SPRITE_H block into the 320x240 VGA adapter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for drawBG / drawChar
// ADDR  | ROM addresses for (row, col) presented, data arrives next cycle
// PLOT  | ROM data valid; pixel written unless clipped or transparent
// DONE  | one-cycle done pulse; chains into a pending char pass if set
module sprite_drawer #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COLOUR_W = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF,
  localparam int AW = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic                doneBG,
  output logic                doneChar,
  output logic                busy,
  output logic [AW-1:0]       charAddr,
  input  logic [COLOUR_W-1:0] charData,
  output logic [16:0]         bgAddr,
  input  logic [COLOUR_W-1:0] bgData,
  output logic [8:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] vgaColour,
  output logic                plot
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PLOT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [8:0]    x0_q, x0_d;
  logic [7:0]    y0_q, y0_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          mode_q, mode_d;      // 0 = background, 1 = character
  logic          pend_q, pend_d;      // char pass queued behind a BG pass

  logic          last_col;
  logic          last_row;
  logic [9:0]    x_sum;
  logic [8:0]    y_sum;

  assign last_col = (col_q == CW'(SPRITE_W - 1));
  assign last_row = (row_q == RW'(SPRITE_H - 1));

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and pixel-walk logic
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        // BG wins a tie so the old sprite is erased before the new one lands
        if (drawBG) begin
          x0_d    = xCoordinate;
          y0_d    = yCoordinate;
          mode_d  = 1'b0;
          pend_d  = drawChar;
          state_d = S_ADDR;
        end else if (drawChar) begin
          x0_d    = xCoordinate;
          y0_d    = yCoordinate;
          mode_d  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_PLOT;
      S_PLOT: begin
        col_d = col_q + CW'(1);
        if (last_col) row_d = row_q + RW'(1);
        state_d = (last_col && last_row) ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        row_d = '0;
        col_d = '0;
        if (pend_q) begin
          pend_d  = 1'b0;
          mode_d  = 1'b1;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: addresses, plot coordinates, colour select and handshake pulses
  always_comb begin
    // Sums kept one bit wider so an overrun clips instead of wrapping
    x_sum     = {1'b0, x0_q} + 10'(col_q);
    y_sum     = {1'b0, y0_q} + 9'(row_q);
    // Power-of-two width makes row*SPRITE_W+col a plain concatenation
    charAddr  = {row_q, col_q};
    bgAddr    = 17'(y_sum) * 17'd320 + 17'(x_sum);
    vgaX      = x_sum[8:0];
    vgaY      = y_sum[7:0];
    vgaColour = mode_q ? charData : bgData;
    plot      = (state_q == S_PLOT) && (x_sum < 10'd320) && (y_sum < 9'd240) &&
                !(mode_q && (charData == TRANSPARENT));
    busy      = (state_q != S_IDLE);
    doneBG    = (state_q == S_DONE) && !mode_q;
    doneChar  = (state_q == S_DONE) && mode_q;
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// Bench for sprite_drawer: ROMs modelled here, expected per-cycle behaviour
// computed from pixel index arithmetic (pass p, pixel k -> plot at
// p*129 + 2 + 2k, done at p*129 + 129).
module tb_sprite_drawer;

  localparam int MAXC = 300;
  localparam int NPIX = 64;
  localparam int PASS = 2 * NPIX + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        drawBG, drawChar;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic        doneBG, doneChar, busy, plot;
  logic [5:0]  charAddr;
  logic [8:0]  charData, bgData;
  logic [16:0] bgAddr;
  logic [8:0]  vgaX;
  logic [7:0]  vgaY;
  logic [8:0]  vgaColour;

  sprite_drawer dut (
    .clock(clock), .reset(reset), .drawBG(drawBG), .drawChar(drawChar),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
    .doneBG(doneBG), .doneChar(doneChar), .busy(busy),
    .charAddr(charAddr), .charData(charData),
    .bgAddr(bgAddr), .bgData(bgData),
    .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .plot(plot)
  );

  always #5 clock = ~clock;

  logic [8:0] sprite_mem [NPIX];

  // Synchronous ROMs: sprite table, and background = low address bits
  always @(posedge clock) begin
    charData <= sprite_mem[charAddr];
    bgData   <= bgAddr[8:0];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_plots  = 0;

  bit exp_plot [MAXC];
  bit exp_busy [MAXC];
  bit exp_dbg  [MAXC];
  bit exp_dch  [MAXC];
  bit exp_ca_ck[MAXC];
  bit exp_ba_ck[MAXC];
  int exp_x    [MAXC];
  int exp_y    [MAXC];
  int exp_col  [MAXC];
  int exp_ca   [MAXC];
  int exp_ba   [MAXC];
  int exp_last;
  int exp_nplot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build(input bit do_bg, input bit do_char, input int x0, input int y0);
    int  np;
    bit  modes[2];
    for (int c = 0; c < MAXC; c++) begin
      exp_plot[c] = 0; exp_busy[c] = 0; exp_dbg[c] = 0; exp_dch[c] = 0;
      exp_ca_ck[c] = 0; exp_ba_ck[c] = 0;
      exp_x[c] = 0; exp_y[c] = 0; exp_col[c] = 0; exp_ca[c] = 0; exp_ba[c] = 0;
    end
    np = 0;
    if (do_bg) begin modes[np] = 0; np++; end
    if (do_char) begin modes[np] = 1; np++; end
    exp_nplot = 0;
    exp_last  = 0;
    for (int p = 0; p < np; p++) begin
      int base;
      base = p * PASS;
      for (int k = 0; k < NPIX; k++) begin
        int x, y, a, colour;
        bit vis;
        x = x0 + k % 8;
        y = y0 + k / 8;
        a = base + 1 + 2 * k;
        if (modes[p]) begin exp_ca_ck[a] = 1; exp_ca[a] = k; end
        else          begin exp_ba_ck[a] = 1; exp_ba[a] = y * 320 + x; end
        colour = modes[p] ? int'(sprite_mem[k]) : ((y * 320 + x) % 512);
        vis = (x < 320) && (y < 240) && !(modes[p] && colour == 511);
        exp_plot[a + 1] = vis;
        exp_x[a + 1]    = x % 512;
        exp_y[a + 1]    = y % 256;
        exp_col[a + 1]  = colour;
        if (vis) exp_nplot++;
      end
      if (modes[p]) exp_dch[base + PASS] = 1;
      else          exp_dbg[base + PASS] = 1;
      exp_last = base + PASS;
    end
    for (int c = 1; c <= exp_last; c++) exp_busy[c] = 1;
  endtask

  task automatic check_cycle(input int c, input string nm);
    check({nm, "/plot"}, plot, exp_plot[c]);
    check({nm, "/busy"}, busy, exp_busy[c]);
    check({nm, "/doneBG"}, doneBG, exp_dbg[c]);
    check({nm, "/doneChar"}, doneChar, exp_dch[c]);
    if (plot) n_plots++;
    if (exp_plot[c]) begin
      check({nm, "/vgaX"}, vgaX, exp_x[c]);
      check({nm, "/vgaY"}, vgaY, exp_y[c]);
      check({nm, "/colour"}, vgaColour, exp_col[c]);
    end
    if (exp_ca_ck[c]) check({nm, "/charAddr"}, charAddr, exp_ca[c]);
    if (exp_ba_ck[c]) check({nm, "/bgAddr"}, bgAddr, exp_ba[c]);
  endtask

  task automatic do_op(input bit b, input bit ch, input int x, input int y, input string nm);
    build(b, ch, x, y);
    @(negedge clock);
    drawBG = b; drawChar = ch;
    xCoordinate = 9'(x); yCoordinate = 8'(y);
    @(posedge clock);
    n_plots = 0;
    for (int c = 1; c <= exp_last + 3; c++) begin
      @(negedge clock);
      if (c == 1) begin
        drawBG = 0; drawChar = 0;
        xCoordinate = 9'($urandom); yCoordinate = 8'($urandom);
      end
      check_cycle(c, nm);
    end
    check({nm, "/plot_count"}, n_plots, exp_nplot);
  endtask

  task automatic load_sprite();
    int placed;
    for (int k = 0; k < NPIX; k++) sprite_mem[k] = 9'($urandom_range(0, 510));
    placed = 0;
    while (placed < 10) begin
      int k;
      k = $urandom_range(0, NPIX - 1);
      if (sprite_mem[k] != 9'h1FF) begin
        sprite_mem[k] = 9'h1FF;
        placed++;
      end
    end
  endtask

  initial begin
    load_sprite();
    reset = 1; drawBG = 1; drawChar = 0;
    xCoordinate = 9'd50; yCoordinate = 8'd60;

    // reset held three cycles with a request pulsed
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("rst/plot", plot, 0);
      check("rst/doneBG", doneBG, 0);
      check("rst/doneChar", doneChar, 0);
      check("rst/busy", busy, 0);
      check("rst/vgaX", vgaX, 0);
      check("rst/vgaY", vgaY, 0);
      drawBG = 0;
    end
    reset = 0;
    @(negedge clock);
    check("idle/busy", busy, 0);

    do_op(1, 0, 96, 222, "bg_main");
    do_op(0, 1, 96, 222, "char_main");
    check("char_main/count54", n_plots, 54);
    do_op(1, 1, 100, 50, "both");
    do_op(1, 0, 316, 236, "bg_corner");
    check("bg_corner/count16", n_plots, 16);

    // reset in the middle of a character pass
    build(0, 1, 96, 222);
    @(negedge clock);
    drawChar = 1; xCoordinate = 9'd96; yCoordinate = 8'd222;
    @(posedge clock);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 1) drawChar = 0;
      check_cycle(c, "abort");
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    check("abort/plot", plot, 0);
    check("abort/busy", busy, 0);
    check("abort/doneChar", doneChar, 0);
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      check("abort_after/plot", plot, 0);
      check("abort_after/doneChar", doneChar, 0);
      check("abort_after/busy", busy, 0);
    end
    do_op(1, 0, 20, 30, "bg_after_abort");

    // randomized requests, including off-screen and edge-straddling sprites
    for (int i = 0; i < 6; i++) begin
      int sel;
      load_sprite();
      sel = $urandom_range(0, 2);
      do_op(sel != 1, sel != 0, $urandom_range(0, 511), $urandom_range(0, 255), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
